// File: rtl/lstm_ctrl_pkg.sv
// lstm_ctrl_pkg: sequencer state encoding and a minimum-1-bit clog2 width helper
package lstm_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, LOAD, CALC, UPDATE, GAP} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r == 0 ? 1 : r;
  endfunction
endpackage

// File: rtl/lstm_bptt_seq_if.sv
// lstm_bptt_seq_if: start/stop control in, array_bp drive pulses, target address and step out
interface lstm_bptt_seq_if #(parameter int WIDTH = 32, parameter int SW = 3);
  logic i_start, i_stop;
  logic o_busy, o_done, o_sel, o_load_in, o_load_h, o_load_bp, o_load_t, o_wr;
  logic [WIDTH-1:0] o_addr_t;
  logic [SW-1:0] o_step;
  modport master(input i_start, i_stop, output o_busy, o_done, o_sel, o_load_in, o_load_h,
                 o_load_bp, o_load_t, o_wr, o_addr_t, o_step);
  modport slave(output i_start, i_stop, input o_busy, o_done, o_sel, o_load_in, o_load_h,
                o_load_bp, o_load_t, o_wr, o_addr_t, o_step);
endinterface

// File: rtl/lstm_tgt_addr_gen.sv
// lstm_tgt_addr_gen: wrapping sequence base plus the step-0 target stream (go starts it, cnt = settle count, adv steps base)
module lstm_tgt_addr_gen
  import lstm_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_ITERATIONS = 8,
  parameter int NUM_SEQ = 2,
  parameter int CW = clog2(43)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             s0,
  input  logic             adv,
  input  logic [CW-1:0]    cnt,
  output logic             load_t,
  output logic [WIDTH-1:0] addr_t
);
  localparam logic [WIDTH-1:0] N = WIDTH'(NUM_ITERATIONS);
  localparam logic [WIDTH-1:0] TOP = WIDTH'(NUM_SEQ * NUM_ITERATIONS);
  logic [WIDTH-1:0] base;
  logic stream;
  // go presents base for settle cycle 0; settle count k then yields base+k on cycle k+1
  always_comb stream = s0 && 32'(cnt) < NUM_ITERATIONS;
  always_ff @(posedge clk)
    if (rst) begin
      base <= '0;
      load_t <= 1'b0;
      addr_t <= '0;
    end else begin
      if (adv) base <= (base + N == TOP) ? '0 : base + N;
      load_t <= go || stream;
      if (go) addr_t <= base;
      else if (stream) addr_t <= base + WIDTH'(cnt);
    end
endmodule

// File: rtl/lstm_bptt_seq.sv
// lstm_bptt_seq: autonomous timestep/batch sequencer (clk, rst, bus: start/stop in, array_bp pulses out)
module lstm_bptt_seq
  import lstm_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NUM_ITERATIONS = 8,
  parameter int SETTLE_CYC = 43,
  parameter int BATCH = 1,
  parameter int NUM_SEQ = 2
) (
  input logic            clk,
  input logic            rst,
  lstm_bptt_seq_if.master bus
);
  localparam int SW = clog2(NUM_ITERATIONS);
  localparam int CW = clog2(SETTLE_CYC);
  localparam int BW = clog2(BATCH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] batch;
  logic stop_q, last_step, last_batch, go, adv, s0;
  always_comb begin
    last_step = bus.o_step == SW'(NUM_ITERATIONS - 1);
    last_batch = batch == BW'(BATCH - 1);
    go = (state == IDLE && bus.i_start) || (state == GAP && !bus.o_done);
    adv = (state == CALC && last_step && !last_batch) || state == UPDATE;
    s0 = state == SETTLE && bus.o_step == '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      batch <= '0;
      stop_q <= 1'b0;
      bus.o_busy <= 1'b0;
      bus.o_done <= 1'b0;
      bus.o_sel <= 1'b0;
      bus.o_load_in <= 1'b0;
      bus.o_load_h <= 1'b0;
      bus.o_load_bp <= 1'b0;
      bus.o_wr <= 1'b0;
      bus.o_step <= '0;
    end else begin
      bus.o_load_in <= 1'b0;
      bus.o_load_h <= 1'b0;
      bus.o_load_bp <= 1'b0;
      bus.o_wr <= 1'b0;
      bus.o_done <= 1'b0;
      if (bus.i_stop && state != IDLE) stop_q <= 1'b1;
      case (state)
        IDLE: if (bus.i_start) begin
          state <= SETTLE;
          cnt <= '0;
          bus.o_step <= '0;
          bus.o_sel <= 1'b0;
          bus.o_busy <= 1'b1;
          stop_q <= bus.i_stop;
        end
        SETTLE: if (cnt == CW'(SETTLE_CYC - 1)) begin
          state <= LOAD;
          bus.o_load_in <= 1'b1;
        end else cnt <= cnt + 1'b1;
        LOAD: begin
          state <= CALC;
          bus.o_load_h <= 1'b1;
          bus.o_load_bp <= 1'b1;
        end
        CALC: if (!last_step) begin
          bus.o_step <= bus.o_step + 1'b1;
          bus.o_sel <= 1'b1;
          cnt <= '0;
          state <= SETTLE;
        end else begin
          bus.o_sel <= 1'b0;
          if (last_batch) begin
            state <= UPDATE;
            bus.o_wr <= 1'b1;
          end else begin
            batch <= batch + 1'b1;
            state <= GAP;
          end
        end
        // i_stop arriving in the UPDATE cycle itself still ends this batch
        UPDATE: begin
          batch <= '0;
          state <= GAP;
          bus.o_done <= stop_q || bus.i_stop;
        end
        GAP: begin
          bus.o_step <= '0;
          cnt <= '0;
          if (bus.o_done) begin
            state <= IDLE;
            bus.o_busy <= 1'b0;
            stop_q <= 1'b0;
          end else state <= SETTLE;
        end
        default: state <= IDLE;
      endcase
    end
  lstm_tgt_addr_gen #(
    .WIDTH(WIDTH), .NUM_ITERATIONS(NUM_ITERATIONS), .NUM_SEQ(NUM_SEQ), .CW(CW)
  ) tgt (
    .clk(clk), .rst(rst), .go(go), .s0(s0), .adv(adv), .cnt(cnt),
    .load_t(bus.o_load_t), .addr_t(bus.o_addr_t)
  );
endmodule

// File: tb/tb_lstm_bptt_seq.sv
// tb_lstm_bptt_seq: directed plus randomized run of lstm_bptt_seq against a schedule-level reference model
module tb_lstm_bptt_seq;
  localparam int N = 4, S = 6, B = 2, NS = 3, M = NS * N, P = S + 2, BODY = N * P;
  localparam int INF = 32'h7fffffff;
  logic clk = 1'b0, rst = 1'b1;
  lstm_bptt_seq_if #(.WIDTH(8), .SW(2)) bus ();
  lstm_bptt_seq #(.WIDTH(8), .NUM_ITERATIONS(N), .SETTLE_CYC(S), .BATCH(B), .NUM_SEQ(NS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  int n_pass = 0, n_total = 0, cyc = 0;
  bit run = 0;
  int rs = 0, base0 = 0, stop_t = INF;
  bit e_busy, e_done, e_sel, e_in, e_h, e_wr, e_t;
  int e_addr = 0, e_step = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
  endtask
  // Each run is a chain of sequences: BODY cycles of timesteps, UPDATE if it closes a batch, then GAP.
  // The run ends after the first batch-closing sequence whose UPDATE cycle is at/after the stop request.
  task automatic model(input bit r, input bit st, input bit sp);
    int o, j, t0, len, stp, q, base;
    bit fin, bend;
    cyc++;
    {e_busy, e_done, e_sel, e_in, e_h, e_wr, e_t} = '0;
    e_step = 0;
    if (r) begin
      run = 0;
      base0 = 0;
      e_addr = 0;
      return;
    end
    if (run) begin
      if (sp && stop_t == INF) stop_t = cyc - 1;
    end else if (st) begin
      run = 1;
      rs = cyc - 1;
      stop_t = sp ? cyc - 1 : INF;
    end
    if (!run) return;
    o = cyc - rs - 1;
    j = 0;
    t0 = rs + 1;
    forever begin
      bend = (j % B) == B - 1;
      len = BODY + 1 + (bend ? 1 : 0);
      fin = bend && (t0 + BODY >= stop_t);
      if (o < len) break;
      if (fin) begin
        run = 0;
        base0 = (base0 + (j + 1) * N) % M;
        return;
      end
      o -= len;
      t0 += len;
      j++;
    end
    base = (base0 + j * N) % M;
    e_busy = 1;
    if (o < BODY) begin
      stp = o / P;
      q = o % P;
      e_step = stp;
      e_sel = stp > 0;
      e_in = q == S;
      e_h = q == S + 1;
      if (stp == 0 && q <= N) begin
        e_t = 1;
        e_addr = base + (q > 0 ? q - 1 : 0);
      end
    end else begin
      e_step = N - 1;
      if (bend && o == BODY) e_wr = 1;
      else e_done = fin;
    end
  endtask
  task automatic tick(input bit st, input bit sp, input bit r);
    bus.i_start = st;
    bus.i_stop = sp;
    rst = r;
    @(posedge clk);
    #1;
    model(r, st, sp);
    chk("busy", 32'(bus.o_busy), 32'(e_busy));
    chk("done", 32'(bus.o_done), 32'(e_done));
    chk("sel", 32'(bus.o_sel), 32'(e_sel));
    chk("load_in", 32'(bus.o_load_in), 32'(e_in));
    chk("load_h", 32'(bus.o_load_h), 32'(e_h));
    chk("load_bp", 32'(bus.o_load_bp), 32'(e_h));
    chk("wr", 32'(bus.o_wr), 32'(e_wr));
    chk("load_t", 32'(bus.o_load_t), 32'(e_t));
    chk("addr_t", 32'(bus.o_addr_t), e_addr);
    chk("step", 32'(bus.o_step), e_step);
  endtask
  task automatic drain();
    for (int i = 0; i < 400 && e_busy; i++) tick(0, 0, 0);
    chk("drain_idle", 32'(bus.o_busy), 32'd0);
  endtask
  initial begin
    bus.i_start = 1'b0;
    bus.i_stop = 1'b0;
    repeat (3) tick(0, 0, 1);
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    for (int i = 1; i <= 140; i++) tick(i == 50, 0, 0);
    tick(0, 1, 0);
    drain();
    repeat (2) tick(0, 0, 1);
    tick(1, 0, 0);
    repeat (9) tick(0, 0, 0);
    tick(0, 1, 0);
    drain();
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (40) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(1, 0, 0);
    repeat (15) tick(0, 0, 0);
    tick(0, 0, 1);
    tick(0, 0, 0);
    tick(1, 0, 0);
    repeat (12) tick(0, 0, 0);
    tick(0, 1, 0);
    drain();
    repeat (20) begin
      int n;
      repeat ($urandom_range(0, 5)) tick(0, $urandom_range(0, 3) == 0, 0);
      tick(1, $urandom_range(0, 3) == 0, 0);
      n = $urandom_range(5, 220);
      for (int i = 0; i < n; i++)
        tick($urandom_range(0, 15) == 0, $urandom_range(0, 60) == 0, $urandom_range(0, 400) == 0);
      tick(0, 1, 0);
      drain();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
